// File: rtl/secam_line_sequencer_if.sv
// Strobe, sample and control bundle between the SECAM line timing source,
// the line sequencer and the downstream encoder.
interface secam_line_sequencer_if;
  logic              newline;
  logic              newframe;
  logic signed [7:0] yuv_u_in;
  logic signed [7:0] yuv_v_in;
  logic              even_line;
  logic              enabled;
  logic signed [7:0] yuv_u;
  logic signed [7:0] yuv_v;
  logic              newframe_out;

  modport master (
    output newline, newframe, yuv_u_in, yuv_v_in,
    input  even_line, enabled, yuv_u, yuv_v, newframe_out
  );

  modport slave (
    input  newline, newframe, yuv_u_in, yuv_v_in,
    output even_line, enabled, yuv_u, yuv_v, newframe_out
  );
endinterface

// File: rtl/secam_line_sequencer.sv
// Line/frame sequencer ahead of the SECAM encoder: Db/Dr alternation, carrier window,
// saturated U/V and a re-timed frame strobe, all registered once after decode.
module secam_line_sequencer #(
  parameter int REST_START   = 400,
  parameter int ACTIVE_START = 560,
  parameter int ACTIVE_END   = 3040,
  parameter int VBLANK_LINES = 23,
  parameter int U_LIMIT      = 100,
  parameter int V_LIMIT      = 100
) (
  input logic                   clk,
  input logic                   rst,
  secam_line_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_OFF    = 2'd1,
    ST_REST   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_e;

  localparam logic signed [8:0] U_LIM9 = 9'(U_LIMIT);
  localparam logic signed [8:0] V_LIM9 = 9'(V_LIMIT);

  // Clamp at 9 bits so that -128 can be negated without overflow.
  function automatic logic signed [7:0] sat8(input logic signed [7:0] x,
                                             input logic signed [8:0] lim);
    logic signed [8:0] xe;
    logic signed [8:0] neg;
    logic signed [7:0] res;
    xe  = {x[7], x};
    neg = -lim;
    if (xe > lim) begin
      res = lim[7:0];
    end else if (xe < neg) begin
      res = neg[7:0];
    end else begin
      res = x;
    end
    return res;
  endfunction

  state_e            state_q,        state_d;
  logic [11:0]       h_cnt_q,        h_cnt_d;
  logic [9:0]        line_cnt_q,     line_cnt_d;
  logic              line_par_q,     line_par_d;
  logic              frame_par_q,    frame_par_d;
  logic              nf_dly_q,       nf_dly_d;
  logic              even_line_q,    even_line_d;
  logic              enabled_q,      enabled_d;
  logic signed [7:0] yuv_u_q,        yuv_u_d;
  logic signed [7:0] yuv_v_q,        yuv_v_d;
  logic              newframe_out_q, newframe_out_d;

  logic strobe_s;
  logic vis_s;
  logic active_s;

  // Next-state counters, parity, FSM and the decode feeding the output registers.
  always_comb begin
    strobe_s = bus.newline | bus.newframe;

    if (strobe_s) begin
      h_cnt_d = 12'd0;
    end else if (h_cnt_q != 12'hFFF) begin
      h_cnt_d = h_cnt_q + 12'd1;
    end else begin
      h_cnt_d = h_cnt_q;
    end

    if (bus.newframe) begin
      line_cnt_d = 10'd0;
    end else if (bus.newline && (line_cnt_q != 10'h3FF)) begin
      line_cnt_d = line_cnt_q + 10'd1;
    end else begin
      line_cnt_d = line_cnt_q;
    end

    // Line parity only advances once frame timing is locked.
    line_par_d  = line_par_q;
    frame_par_d = frame_par_q;
    if (bus.newframe) begin
      line_par_d  = frame_par_q;
      frame_par_d = ~frame_par_q;
    end else if (bus.newline && (state_q != ST_WAIT)) begin
      line_par_d = ~line_par_q;
    end else begin
      line_par_d = line_par_q;
    end

    // Transitions look at h_cnt_d so the state lines up with the h_cnt it describes.
    state_d = state_q;
    case (state_q)
      ST_WAIT: begin
        if (bus.newframe) begin
          state_d = ST_OFF;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_OFF: begin
        if (strobe_s) begin
          state_d = ST_OFF;
        end else if (h_cnt_d == 12'(REST_START)) begin
          state_d = ST_REST;
        end else begin
          state_d = ST_OFF;
        end
      end
      ST_REST: begin
        if (strobe_s) begin
          state_d = ST_OFF;
        end else if (h_cnt_d == 12'(ACTIVE_START)) begin
          state_d = ST_ACTIVE;
        end else begin
          state_d = ST_REST;
        end
      end
      ST_ACTIVE: begin
        if (strobe_s || (h_cnt_d == 12'(ACTIVE_END))) begin
          state_d = ST_OFF;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase

    vis_s     = (line_cnt_q >= 10'(VBLANK_LINES));
    active_s  = vis_s && (state_q == ST_ACTIVE);
    enabled_d = vis_s && ((state_q == ST_REST) || (state_q == ST_ACTIVE));
    if (active_s) begin
      yuv_u_d = sat8(bus.yuv_u_in, U_LIM9);
      yuv_v_d = sat8(bus.yuv_v_in, V_LIM9);
    end else begin
      yuv_u_d = 8'sd0;
      yuv_v_d = 8'sd0;
    end
    even_line_d    = line_par_q;
    nf_dly_d       = bus.newframe;
    newframe_out_d = nf_dly_q;
  end

  // State, counters and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_WAIT;
      h_cnt_q        <= 12'd0;
      line_cnt_q     <= 10'd0;
      line_par_q     <= 1'b0;
      frame_par_q    <= 1'b0;
      nf_dly_q       <= 1'b0;
      even_line_q    <= 1'b0;
      enabled_q      <= 1'b0;
      yuv_u_q        <= 8'sd0;
      yuv_v_q        <= 8'sd0;
      newframe_out_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      h_cnt_q        <= h_cnt_d;
      line_cnt_q     <= line_cnt_d;
      line_par_q     <= line_par_d;
      frame_par_q    <= frame_par_d;
      nf_dly_q       <= nf_dly_d;
      even_line_q    <= even_line_d;
      enabled_q      <= enabled_d;
      yuv_u_q        <= yuv_u_d;
      yuv_v_q        <= yuv_v_d;
      newframe_out_q <= newframe_out_d;
    end
  end

  assign bus.even_line    = even_line_q;
  assign bus.enabled      = enabled_q;
  assign bus.yuv_u        = yuv_u_q;
  assign bus.yuv_v        = yuv_v_q;
  assign bus.newframe_out = newframe_out_q;

endmodule

// File: tb/tb_secam_line_sequencer.sv
// Directed line/frame sequences with random U/V, every output checked each cycle
// against a timing-window model of the sequencer.
module tb_secam_line_sequencer;

  localparam int REST_START   = 400;
  localparam int ACTIVE_START = 560;
  localparam int ACTIVE_END   = 3040;
  localparam int VBLANK_LINES = 23;
  localparam int U_LIMIT      = 100;
  localparam int V_LIMIT      = 100;

  logic clk = 1'b0;
  logic rst;

  secam_line_sequencer_if bus ();

  secam_line_sequencer #(
    .REST_START  (REST_START),
    .ACTIVE_START(ACTIVE_START),
    .ACTIVE_END  (ACTIVE_END),
    .VBLANK_LINES(VBLANK_LINES),
    .U_LIMIT     (U_LIMIT),
    .V_LIMIT     (V_LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Model view of the timing after a given cycle: which line we are on and when it began.
  typedef struct {
    bit started;
    int line;
    bit par;
    bit fpar;
    int t_strobe;
  } snap_t;

  snap_t m1, m2;
  int    cyc;
  int    hist;
  int    checks;
  int    errors;
  bit    r_p1, r_p2, nf_p1, nf_p2;
  int    u_p1, v_p1;
  logic signed [7:0] pat [8];

  function automatic snap_t reset_snap(int c);
    snap_t s;
    s.started  = 1'b0;
    s.line     = 0;
    s.par      = 1'b0;
    s.fpar     = 1'b0;
    s.t_strobe = c;
    return s;
  endfunction

  function automatic int sat(int x, int lim);
    if (x > lim) return lim;
    if (x < -lim) return -lim;
    return x;
  endfunction

  task automatic check1(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: check this cycle's outputs, then apply this cycle's inputs.
  task automatic step(bit nl, bit nf, bit r, logic signed [7:0] u, logic signed [7:0] v);
    snap_t m0;
    int    n;
    bit    vis, e_en, e_act, e_ev, e_nfo;
    int    eu, ev;
    if (hist >= 2) begin
      n     = cyc - m2.t_strobe;
      vis   = m2.started && (m2.line >= VBLANK_LINES);
      e_en  = vis && (n >= REST_START + 2) && (n < ACTIVE_END + 2);
      e_act = vis && (n >= ACTIVE_START + 2) && (n < ACTIVE_END + 2);
      eu    = e_act ? sat(u_p1, U_LIMIT) : 0;
      ev    = e_act ? sat(v_p1, V_LIMIT) : 0;
      e_ev  = m2.par;
      e_nfo = nf_p2 && !r_p2;
      if (r_p1) begin
        e_en = 1'b0; eu = 0; ev = 0; e_ev = 1'b0; e_nfo = 1'b0;
      end
      check1("enabled",      {7'd0, bus.enabled},      {7'd0, e_en});
      check1("even_line",    {7'd0, bus.even_line},    {7'd0, e_ev});
      check1("newframe_out", {7'd0, bus.newframe_out}, {7'd0, e_nfo});
      check1("yuv_u",        bus.yuv_u,                8'(eu));
      check1("yuv_v",        bus.yuv_v,                8'(ev));
    end
    bus.newline  = nl;
    bus.newframe = nf;
    bus.yuv_u_in = u;
    bus.yuv_v_in = v;
    rst          = r;
    m0 = m1;
    if (r) begin
      m0 = reset_snap(cyc);
    end else if (nf) begin
      m0.line     = 0;
      m0.par      = m1.fpar;
      m0.fpar     = ~m1.fpar;
      m0.started  = 1'b1;
      m0.t_strobe = cyc;
    end else if (nl) begin
      m0.line     = (m1.line < 1023) ? m1.line + 1 : 1023;
      m0.par      = m1.started ? ~m1.par : m1.par;
      m0.t_strobe = cyc;
    end
    m2    = m1;
    m1    = m0;
    nf_p2 = nf_p1;
    nf_p1 = nf;
    r_p2  = r_p1;
    r_p1  = r;
    u_p1  = int'(u);
    v_p1  = int'(v);
    hist++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // kind 0: fixed fu/fv, 1: random, 2: saturation pattern.
  task automatic run(int len, bit nl0, bit nf0, int kind, logic signed [7:0] fu, logic signed [7:0] fv);
    logic signed [7:0] u, v;
    for (int i = 0; i < len; i++) begin
      if (kind == 0) begin
        u = fu; v = fv;
      end else if (kind == 1) begin
        u = 8'($urandom); v = 8'($urandom);
      end else begin
        u = pat[i % 8]; v = pat[(i + 3) % 8];
      end
      step((i == 0) && nl0, (i == 0) && nf0, 1'b0, u, v);
    end
  endtask

  task automatic blank_frame(int len);
    run(len, 1'b0, 1'b1, 1, 8'sd0, 8'sd0);
    for (int i = 1; i < VBLANK_LINES; i++) run(len, 1'b1, 1'b0, 1, 8'sd0, 8'sd0);
  endtask

  initial begin
    pat = '{8'h7f, 8'h80, 8'h63, 8'h9b, 8'h9c, 8'h64, 8'h00, 8'hff};
    checks = 0; errors = 0; cyc = 0; hist = 0;
    r_p1 = 1'b0; r_p2 = 1'b0; nf_p1 = 1'b0; nf_p2 = 1'b0; u_p1 = 0; v_p1 = 0;
    m1 = reset_snap(0);
    m2 = reset_snap(0);
    bus.newline = 1'b0; bus.newframe = 1'b0; bus.yuv_u_in = 8'sd0; bus.yuv_v_in = 8'sd0;
    rst = 1'b1;

    // Reset, then lines without any frame strobe: no carrier, even_line stays 0.
    repeat (3) step(1'b0, 1'b0, 1'b1, 8'sd0, 8'sd0);
    run(50, 1'b0, 1'b0, 1, 8'sd0, 8'sd0);
    repeat (2) run(3200, 1'b1, 1'b0, 1, 8'sd0, 8'sd0);

    // Frame 0: blanking lines long enough to cover the rest window, then visible lines.
    blank_frame(600);
    repeat (2) run(3200, 1'b1, 1'b0, 0, 8'sd40, -8'sd40);
    repeat (2) run(3200, 1'b1, 1'b0, 1, 8'sd0, 8'sd0);
    run(3200, 1'b1, 1'b0, 2, 8'sd0, 8'sd0);

    // Frames 1 and 2: parity order flips per frame.
    run(600, 1'b0, 1'b1, 1, 8'sd0, 8'sd0);
    repeat (4) run(600, 1'b1, 1'b0, 1, 8'sd0, 8'sd0);
    run(600, 1'b0, 1'b1, 1, 8'sd0, 8'sd0);
    repeat (3) run(100, 1'b1, 1'b0, 1, 8'sd0, 8'sd0);

    // Frame 3: newline arrives when h_cnt is 1000, mid-active.
    blank_frame(100);
    run(1001, 1'b1, 1'b0, 1, 8'sd0, 8'sd0);
    run(3200, 1'b1, 1'b0, 1, 8'sd0, 8'sd0);

    // Simultaneous newline+newframe mid-active, then reset mid-active.
    run(1000, 1'b1, 1'b0, 1, 8'sd0, 8'sd0);
    run(100, 1'b1, 1'b1, 1, 8'sd0, 8'sd0);
    for (int i = 1; i < VBLANK_LINES; i++) run(100, 1'b1, 1'b0, 1, 8'sd0, 8'sd0);
    run(1500, 1'b1, 1'b0, 1, 8'sd0, 8'sd0);
    repeat (2) step(1'b0, 1'b0, 1'b1, 8'sd55, 8'sd55);
    run(3, 1'b0, 1'b0, 1, 8'sd0, 8'sd0);
    run(3200, 1'b1, 1'b0, 1, 8'sd0, 8'sd0);

    // Recovery, plus a visible line with a missing newline (h_cnt saturates).
    blank_frame(100);
    run(5000, 1'b1, 1'b0, 1, 8'sd0, 8'sd0);
    run(3200, 1'b1, 1'b0, 1, 8'sd0, 8'sd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
